// File: rtl/spi_sram_responder_pkg.sv
// Shared command codes, mode register reset value and FSM state type for the
// SPI serial-SRAM responder.
package neander_spi_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_WRSR  = 8'h01;
    localparam logic [7:0] MODE_SEQ  = 8'h40;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        RD_DATA,
        WR_DATA,
        STATUS_RD,
        STATUS_WR,
        IGNORE
    } spi_resp_state_t;

endpackage

// File: rtl/spi_sram_responder_if.sv
// Parallel synchronous memory port between the SPI responder (master) and the
// backing RAM (slave). Read data is valid one clk after mem_re.
interface spi_sram_responder_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/spi_sram_responder_pin_sync.sv
// Synchronizes the SPI pins into the clk domain and derives SCLK and CS edge
// pulses. CS edges are only honoured once CS has been seen high after reset.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cs_n,
    input  logic sclk,
    input  logic mosi,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic selected
);
    localparam int TOP = SYNC_STAGES - 1;

    logic [TOP:0] cs_sr;
    logic [TOP:0] sclk_sr;
    logic [TOP:0] mosi_sr;
    logic         cs_q;
    logic         sclk_q;
    logic         armed;

    // CS chain resets to "selected" so a CS held low through reset never
    // produces a falling edge; a real rise must arm the responder first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sr   <= '0;
            sclk_sr <= '0;
            mosi_sr <= '0;
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            cs_sr   <= {cs_sr[TOP-1:0], cs_n};
            sclk_sr <= {sclk_sr[TOP-1:0], sclk};
            mosi_sr <= {mosi_sr[TOP-1:0], mosi};
            cs_q    <= cs_sr[TOP];
            sclk_q  <= sclk_sr[TOP];
            if (cs_rise) armed <= 1'b1;
        end
    end

    assign mosi_s    = mosi_sr[TOP];
    assign sclk_rise = sclk_sr[TOP] & ~sclk_q;
    assign sclk_fall = ~sclk_sr[TOP] & sclk_q;
    assign cs_rise   = cs_sr[TOP] & ~cs_q;
    assign cs_fall   = armed & ~cs_sr[TOP] & cs_q;
    assign selected  = armed & ~cs_sr[TOP];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave emulating a 23LC512-style serial SRAM on a parallel memory
// port. Define SPI_RESP_MODE_REG_EN to add the RDSR/WRSR mode register.
module spi_sram_responder
    import neander_spi_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic spi_cs_n,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic busy,
    spi_sram_responder_if.master mem
);
    spi_resp_state_t   state, state_next;
    logic              mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_in, shift_out, prefetch, mode_reg;
    logic [ADDR_W-1:0] addr, mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q, mem_re_q, re_q;
    logic              is_read, first_pending, byte_done, oe, byte_mode;
    logic [7:0]        rx_byte;
    logic              byte_end;
    logic [ADDR_W-1:0] addr_shifted, addr_next;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs_n      (spi_cs_n),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .selected  (busy)
    );

    assign rx_byte      = {shift_in[6:0], mosi_s};
    assign byte_end     = sclk_rise && (bit_cnt == 3'd7);
    assign addr_shifted = {addr[ADDR_W-2:0], mosi_s};
    assign addr_next    = addr + ADDR_W'(1);

`ifdef SPI_RESP_MODE_REG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           mode_reg <= MODE_SEQ;
        else if (state == STATUS_WR && byte_end) mode_reg <= rx_byte;
    end
    assign byte_mode = (mode_reg[7:6] == 2'b00);
`else
    assign mode_reg  = MODE_SEQ;
    assign byte_mode = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (cs_fall) state_next = CMD;
            CMD: begin
                if (byte_end) begin
                    case (rx_byte)
                        CMD_READ, CMD_WRITE: state_next = ADDR_HI;
`ifdef SPI_RESP_MODE_REG_EN
                        CMD_RDSR:            state_next = STATUS_RD;
                        CMD_WRSR:            state_next = STATUS_WR;
`endif
                        default:             state_next = IGNORE;
                    endcase
                end
            end
            ADDR_HI:   if (byte_end) state_next = ADDR_LO;
            ADDR_LO:   if (byte_end) state_next = is_read ? RD_DATA : WR_DATA;
            STATUS_WR: if (byte_end) state_next = IGNORE;
            default:   state_next = state;
        endcase
        if (cs_rise) state_next = IDLE;
    end

    // The next read byte is fetched on the rise that samples bit 0, so the
    // prefetch register is already valid when the byte-boundary fall loads it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= '0;
            shift_in      <= '0;
            shift_out     <= '0;
            prefetch      <= '0;
            addr          <= '0;
            is_read       <= 1'b0;
            first_pending <= 1'b0;
            byte_done     <= 1'b0;
            oe            <= 1'b0;
            re_q          <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            re_q     <= mem_re_q;
            if (re_q) prefetch <= mem.mem_rdata;
            if (cs_fall) begin
                bit_cnt       <= '0;
                addr          <= '0;
                is_read       <= 1'b0;
                first_pending <= 1'b0;
                byte_done     <= 1'b0;
                oe            <= 1'b0;
            end
            if (cs_rise) oe <= 1'b0;
            if (sclk_rise && state != IDLE && state != IGNORE) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= rx_byte;
                case (state)
                    CMD: begin
                        if (byte_end) begin
                            is_read       <= (rx_byte == CMD_READ);
                            first_pending <= 1'b1;
                        end
                    end
                    ADDR_HI: addr <= addr_shifted;
                    ADDR_LO: begin
                        addr <= addr_shifted;
                        if (byte_end && is_read) begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= addr_shifted;
                        end
                    end
                    WR_DATA: begin
                        if (byte_end) begin
                            byte_done <= 1'b1;
                            if (!(byte_mode && byte_done)) begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= addr;
                                mem_wdata_q <= rx_byte;
                                addr        <= addr_next;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (byte_end && !byte_mode) begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= addr_next;
                        end
                    end
                    default: ;
                endcase
            end
            if (sclk_fall && (state == RD_DATA || state == STATUS_RD)) begin
                if (first_pending) begin
                    shift_out     <= (state == STATUS_RD) ? mode_reg : prefetch;
                    oe            <= 1'b1;
                    first_pending <= 1'b0;
                end else if (bit_cnt == 3'd0) begin
                    if (state == STATUS_RD) begin
                        shift_out <= mode_reg;
                    end else begin
                        shift_out <= byte_mode ? 8'h00 : prefetch;
                        addr      <= addr_next;
                    end
                end else begin
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

    assign spi_miso      = oe & shift_out[7];
    assign spi_miso_oe   = oe;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_re    = mem_re_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: a transaction-level SRAM model predicts
// memory strobes and MISO bytes; a monitor checks strobes as they appear.
module tb_spi_sram_responder;

    logic clk = 1'b0;
    logic reset_n;
    logic spi_cs_n, spi_sclk, spi_mosi;
    logic spi_miso, spi_miso_oe, busy;

    spi_sram_responder_if #(.ADDR_W(16)) mif ();

    spi_sram_responder #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .busy        (busy),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem       [65536];
    logic [7:0]  model_mem [65536];
    logic [23:0] exp_we [$];
    logic [15:0] exp_re [$];
    bit          byte_mode = 1'b0;
    bit          watch_oe  = 1'b0;
    bit          oe_seen   = 1'b0;
    logic [7:0]  exp_mode  = 8'h40;
    logic [7:0]  wbuf [4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Bench-side RAM answering the responder's parallel port.
    always @(posedge clk) begin
        if (mif.mem_we) mem[mif.mem_addr] = mif.mem_wdata;
        if (mif.mem_re) mif.mem_rdata <= mem[mif.mem_addr];
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (mif.mem_we || mif.mem_re)
                checkOutput("we_re_exclusive", 32'(mif.mem_we & mif.mem_re), 0);
            if (mif.mem_we) begin
                checkOutput("we_expected", 32'(exp_we.size() != 0), 1);
                if (exp_we.size() != 0) begin
                    logic [23:0] e;
                    e = exp_we.pop_front();
                    checkOutput("we_addr", 32'(mif.mem_addr), 32'(e[23:8]));
                    checkOutput("we_data", 32'(mif.mem_wdata), 32'(e[7:0]));
                end
            end
            if (mif.mem_re) begin
                checkOutput("re_expected", 32'(exp_re.size() != 0), 1);
                if (exp_re.size() != 0) begin
                    logic [15:0] r;
                    r = exp_re.pop_front();
                    checkOutput("re_addr", 32'(mif.mem_addr), 32'(r));
                end
            end
            if (watch_oe && spi_miso_oe) oe_seen = 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            wait_clks(6);
            rx[i]    = spi_miso;
            spi_sclk = 1'b1;
            wait_clks(6);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clks(6);
    endtask

    task automatic cs_end();
        wait_clks(6);
        spi_cs_n = 1'b1;
        wait_clks(12);
    endtask

    // One read or write transaction; expectations are queued before the bytes
    // that provoke them so the monitor always finds them waiting.
    task automatic applyStimulus(input bit is_write, input logic [15:0] addr, input int nbytes,
                                 input logic [7:0] wdata [4]);
        logic [7:0]  rx;
        logic [15:0] a;
        cs_begin();
        spi_xfer(is_write ? 8'h02 : 8'h03, 8, rx);
        spi_xfer(addr[15:8], 8, rx);
        if (!is_write) exp_re.push_back(addr);
        spi_xfer(addr[7:0], 8, rx);
        for (int k = 0; k < nbytes; k++) begin
            a = addr + 16'(k);
            if (is_write) begin
                if (!byte_mode || k == 0) begin
                    exp_we.push_back({a, wdata[k]});
                    model_mem[a] = wdata[k];
                end
                spi_xfer(wdata[k], 8, rx);
            end else begin
                if (!byte_mode) exp_re.push_back(a + 16'd1);
                spi_xfer(8'h00, 8, rx);
                checkOutput("miso_byte", 32'(rx), (byte_mode && k > 0) ? 32'h0 : 32'(model_mem[a]));
            end
        end
        cs_end();
    endtask

    task automatic status_read(input int nbytes);
        logic [7:0] rx;
        cs_begin();
        spi_xfer(8'h05, 8, rx);
        for (int k = 0; k < nbytes; k++) begin
            spi_xfer(8'h00, 8, rx);
            checkOutput("rdsr_byte", 32'(rx), 32'(exp_mode));
        end
        cs_end();
    endtask

    task automatic status_write(input logic [7:0] v);
        logic [7:0] rx;
        cs_begin();
        spi_xfer(8'h01, 8, rx);
        spi_xfer(v, 8, rx);
        cs_end();
        exp_mode = v;
    endtask

    initial begin
        logic [7:0]  rx;
        logic [7:0]  b;
        logic [15:0] ra;
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            b            = 8'($urandom);
            mem[i]       = b;
            model_mem[i] = b;
        end
        wait_clks(3);
        checkOutput("reset_miso", 32'(spi_miso), 0);
        checkOutput("reset_oe", 32'(spi_miso_oe), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_we", 32'(mif.mem_we), 0);
        checkOutput("reset_re", 32'(mif.mem_re), 0);
        checkOutput("reset_addr", 32'(mif.mem_addr), 0);
        checkOutput("reset_wdata", 32'(mif.mem_wdata), 0);
        reset_n = 1'b1;
        wait_clks(10);

        $display("[TB] directed write / read / wrap");
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'h00; wbuf[3] = 8'h00;
        applyStimulus(1'b1, 16'h0010, 2, wbuf);
        applyStimulus(1'b0, 16'h0010, 2, wbuf);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        applyStimulus(1'b1, 16'hFFFF, 2, wbuf);
        applyStimulus(1'b0, 16'hFFFF, 2, wbuf);

        $display("[TB] aborted write");
        cs_begin();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'hC3, 5, rx);
        cs_end();
        applyStimulus(1'b0, 16'h0020, 1, wbuf);

        $display("[TB] unknown command");
        oe_seen  = 1'b0;
        watch_oe = 1'b1;
        cs_begin();
        spi_xfer(8'h9F, 8, rx);
        for (int k = 0; k < 3; k++) spi_xfer(8'($urandom), 8, rx);
        cs_end();
        watch_oe = 1'b0;
        checkOutput("ignore_oe", 32'(oe_seen), 0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), ra, $urandom_range(1, 4), wbuf);
        end

        $display("[TB] reset during read");
        ra = 16'h0340;
        cs_begin();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(ra[15:8], 8, rx);
        exp_re.push_back(ra);
        spi_xfer(ra[7:0], 8, rx);
        spi_xfer(8'h00, 3, rx);
        reset_n = 1'b0;
        wait_clks(2);
        checkOutput("midreset_miso", 32'(spi_miso), 0);
        checkOutput("midreset_oe", 32'(spi_miso_oe), 0);
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_we", 32'(mif.mem_we), 0);
        checkOutput("midreset_re", 32'(mif.mem_re), 0);
        checkOutput("midreset_addr", 32'(mif.mem_addr), 0);
        reset_n = 1'b1;
        wait_clks(4);
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h30, 8, rx);
        spi_xfer(8'h77, 8, rx);
        checkOutput("postreset_busy", 32'(busy), 0);
        cs_end();
        wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
        applyStimulus(1'b1, 16'h0030, 2, wbuf);
        applyStimulus(1'b0, 16'h0030, 2, wbuf);

`ifdef SPI_RESP_MODE_REG_EN
        $display("[TB] mode register");
        status_read(2);
        status_write(8'h00);
        status_read(1);
        byte_mode = 1'b1;
        wbuf[0] = 8'h81; wbuf[1] = 8'h18;
        applyStimulus(1'b1, 16'h0050, 2, wbuf);
        applyStimulus(1'b0, 16'h0050, 2, wbuf);
        byte_mode = 1'b0;
        status_write(8'h40);
        status_read(1);
        applyStimulus(1'b0, 16'h0050, 2, wbuf);
`endif

        wait_clks(10);
        checkOutput("we_queue_drained", 32'(exp_we.size()), 0);
        checkOutput("re_queue_drained", 32'(exp_re.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
